timer_arbiter: RTL and testbench

Shares the single 2-second timing counter (WIDTH-bit, all-ones terminal count, `o_TwoSec`/`o_RstOK` outputs) among several game-flow requesters: player card reveal, dealer card reveal and result hold. For the granted requester it clears the counter, runs it, and returns a one-cycle completion pulse. It sits between the BlackJack controller sub-FSMs and the counter, and is the only driver of the counter's `i_ActCounter` and `i_RstCounter`.

---
 rtl/timer_arbiter_if.sv | 24 ++
 rtl/timer_arbiter.sv | 144 ++++++++++++++
 tb/tb_timer_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/timer_arbiter_if.sv
// Requester-side bundle for timer_arbiter: level requests in, owner grant,
// completion pulse and busy flag out.
interface timer_arbiter_if #(
   parameter int NREQ = 3
);
   logic [NREQ-1:0] i_Req;
   logic [NREQ-1:0] o_Grant;
   logic [NREQ-1:0] o_Done;
   logic            o_Busy;

   modport master (
      output i_Req,
      input  o_Grant,
      input  o_Done,
      input  o_Busy
   );

   modport slave (
      input  i_Req,
      output o_Grant,
      output o_Done,
      output o_Busy
   );
endinterface

// File: rtl/timer_arbiter.sv
// Round-robin owner of the shared 2-second counter: clears it, runs it for the
// granted requester and returns a one-cycle Done pulse on that requester's bit.
module timer_arbiter #(
   parameter int NREQ  = 3,
   parameter int WIDTH = 12
) (
   input  logic             clk_2K,
   input  logic             i_Reset,
   timer_arbiter_if.slave   arb,
   output logic             o_RstCounter,
   output logic             o_ActCounter,
   input  logic             i_RstOK,
   input  logic             i_TwoSec
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

   if (NREQ < 1 || WIDTH < 1) begin : g_param_check
      $error("timer_arbiter: NREQ and WIDTH must both be at least 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_DONE,
      S_RELEASE
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [NREQ-1:0] r_grant;
   logic [NREQ-1:0] w_grant_next;
   logic [PW-1:0]   r_ptr;
   logic [PW-1:0]   w_ptr_next;

   logic [NREQ-1:0] w_upper_mask;
   logic [NREQ-1:0] w_req_upper;
   logic [NREQ-1:0] w_pick_upper;
   logic [NREQ-1:0] w_pick_any;
   logic [NREQ-1:0] w_pick;
   logic [PW-1:0]   w_idx_chain [NREQ+1];
   logic [PW-1:0]   w_grant_idx;
   logic            w_req_owner;

   logic [NREQ-1:0] w_done;
   logic            w_busy;
   logic            w_rst_counter;
   logic            w_act_counter;

   // Bits above the pointer win first; if none is requesting, wrap to the lowest.
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_bit
      localparam logic [PW-1:0] BIT_IDX = PW'(gi);
      assign w_upper_mask[gi]    = (BIT_IDX > r_ptr);
      assign w_idx_chain[gi + 1] = w_idx_chain[gi] | (r_grant[gi] ? BIT_IDX : '0);
   end

   assign w_idx_chain[0] = '0;
   assign w_grant_idx    = w_idx_chain[NREQ];

   assign w_req_upper  = arb.i_Req & w_upper_mask;
   assign w_pick_upper = w_req_upper & (-w_req_upper);
   assign w_pick_any   = arb.i_Req & (-arb.i_Req);
   assign w_pick       = (|w_req_upper) ? w_pick_upper : w_pick_any;
   assign w_req_owner  = |(arb.i_Req & r_grant);

   always_ff @(posedge clk_2K) begin
      if (i_Reset) begin
         r_state <= S_IDLE;
         r_grant <= '0;
         r_ptr   <= PTR_RST;
      end else begin
         r_state <= w_state_next;
         r_grant <= w_grant_next;
         r_ptr   <= w_ptr_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_grant_next = r_grant;
      w_ptr_next   = r_ptr;
      case (r_state)
         S_IDLE: begin
            if (|arb.i_Req) begin
               w_grant_next = w_pick;
               w_state_next = S_CLEAR;
            end
         end
         S_CLEAR: begin
            if (i_RstOK) begin
               w_state_next = S_RUN;
            end
         end
         S_RUN: begin
            // A dropped request outranks a simultaneous terminal count.
            if (!w_req_owner) begin
               w_ptr_next   = w_grant_idx;
               w_grant_next = '0;
               w_state_next = S_IDLE;
            end else if (i_TwoSec) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            w_ptr_next   = w_grant_idx;
            w_state_next = S_RELEASE;
         end
         S_RELEASE: begin
            if (!w_req_owner) begin
               w_grant_next = '0;
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_grant_next = '0;
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_comb begin
      w_done        = '0;
      w_busy        = 1'b1;
      w_rst_counter = 1'b0;
      w_act_counter = 1'b0;
      case (r_state)
         S_IDLE:    w_busy        = 1'b0;
         S_CLEAR:   w_rst_counter = 1'b1;
         S_RUN:     w_act_counter = 1'b1;
         S_DONE:    w_done        = r_grant;
         S_RELEASE: w_done        = '0;
         default:   w_busy        = 1'b0;
      endcase
   end

   assign arb.o_Grant  = r_grant;
   assign arb.o_Done   = w_done;
   assign arb.o_Busy   = w_busy;
   assign o_RstCounter = w_rst_counter;
   assign o_ActCounter = w_act_counter;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter: short table of vectors with a hand-driven
// counter, then long sequences against a behavioural 2-second counter.
module tb_timer_arbiter;
   localparam int NREQ  = 3;
   localparam int WIDTH = 12;
   localparam int NV    = 24;
   localparam logic [WIDTH-1:0] TERM = '1;

   logic             clk_2K = 1'b0;
   logic             i_Reset = 1'b1;
   logic             o_RstCounter;
   logic             o_ActCounter;
   logic             i_RstOK;
   logic             i_TwoSec;
   logic             use_model = 1'b0;
   logic             tbl_rstok = 1'b0;
   logic             tbl_twosec = 1'b0;
   logic [WIDTH-1:0] cnt = '0;
   int               checks = 0;
   int               failures = 0;

   timer_arbiter_if #(.NREQ(NREQ)) arb ();

   timer_arbiter #(
      .NREQ  (NREQ),
      .WIDTH (WIDTH)
   ) dut (
      .clk_2K       (clk_2K),
      .i_Reset      (i_Reset),
      .arb          (arb),
      .o_RstCounter (o_RstCounter),
      .o_ActCounter (o_ActCounter),
      .i_RstOK      (i_RstOK),
      .i_TwoSec     (i_TwoSec)
   );

   always #5 clk_2K = ~clk_2K;

   // Counter model: synchronous clear, count while active, RstOK follows the clear request.
   always @(posedge clk_2K) begin
      if (o_RstCounter) cnt <= '0;
      else if (o_ActCounter) cnt <= cnt + WIDTH'(1);
   end

   assign i_RstOK  = use_model ? o_RstCounter : tbl_rstok;
   assign i_TwoSec = use_model ? (cnt == TERM) : tbl_twosec;

   typedef struct {
      logic       rst;
      logic [2:0] req;
      logic       rstok;
      logic       twosec;
      logic [8:0] exp;   // {grant, done, busy, rstcounter, actcounter}
   } vec_t;

   vec_t tbl [NV];

   function automatic logic [8:0] cur();
      return {arb.o_Grant, arb.o_Done, arb.o_Busy, o_RstCounter, o_ActCounter};
   endfunction

   task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got grant=%b done=%b busy=%b rst=%b act=%b, expected grant=%b done=%b busy=%b rst=%b act=%b",
                  name, got[8:6], got[5:3], got[2], got[1], got[0],
                  want[8:6], want[5:3], want[2], want[1], want[0]);
      end
   endtask

   task automatic tick();
      @(posedge clk_2K);
      #1;
   endtask

   task automatic do_reset();
      i_Reset   = 1'b1;
      arb.i_Req = '0;
      tick();
      check("reset", cur(), 9'b000_000_0_0_0);
      i_Reset = 1'b0;
   endtask

   initial begin
      logic [2:0] rr_order [4];
      logic [2:0] e;
      logic [8:0] want;
      int         n;

      tbl[0]  = '{1'b1, 3'b000, 1'b0, 1'b0, 9'b000_000_0_0_0};
      tbl[1]  = '{1'b0, 3'b001, 1'b0, 1'b0, 9'b001_000_1_1_0};
      tbl[2]  = '{1'b0, 3'b001, 1'b0, 1'b0, 9'b001_000_1_1_0};
      tbl[3]  = '{1'b0, 3'b001, 1'b1, 1'b0, 9'b001_000_1_0_1};
      tbl[4]  = '{1'b0, 3'b011, 1'b0, 1'b0, 9'b001_000_1_0_1};
      tbl[5]  = '{1'b0, 3'b011, 1'b0, 1'b1, 9'b001_001_1_0_0};
      tbl[6]  = '{1'b0, 3'b011, 1'b0, 1'b0, 9'b001_000_1_0_0};
      tbl[7]  = '{1'b0, 3'b010, 1'b0, 1'b0, 9'b000_000_0_0_0};
      tbl[8]  = '{1'b0, 3'b110, 1'b0, 1'b0, 9'b010_000_1_1_0};
      tbl[9]  = '{1'b0, 3'b110, 1'b1, 1'b1, 9'b010_000_1_0_1};
      tbl[10] = '{1'b0, 3'b100, 1'b0, 1'b1, 9'b000_000_0_0_0};
      tbl[11] = '{1'b0, 3'b101, 1'b0, 1'b0, 9'b100_000_1_1_0};
      tbl[12] = '{1'b0, 3'b101, 1'b1, 1'b0, 9'b100_000_1_0_1};
      tbl[13] = '{1'b0, 3'b101, 1'b0, 1'b1, 9'b100_100_1_0_0};
      tbl[14] = '{1'b0, 3'b001, 1'b0, 1'b0, 9'b100_000_1_0_0};
      tbl[15] = '{1'b0, 3'b001, 1'b0, 1'b0, 9'b000_000_0_0_0};
      tbl[16] = '{1'b0, 3'b001, 1'b0, 1'b0, 9'b001_000_1_1_0};
      tbl[17] = '{1'b1, 3'b001, 1'b1, 1'b0, 9'b000_000_0_0_0};
      tbl[18] = '{1'b0, 3'b111, 1'b0, 1'b0, 9'b001_000_1_1_0};
      tbl[19] = '{1'b0, 3'b000, 1'b0, 1'b0, 9'b001_000_1_1_0};
      tbl[20] = '{1'b0, 3'b000, 1'b1, 1'b0, 9'b001_000_1_0_1};
      tbl[21] = '{1'b0, 3'b000, 1'b0, 1'b0, 9'b000_000_0_0_0};
      tbl[22] = '{1'b0, 3'b101, 1'b0, 1'b0, 9'b100_000_1_1_0};
      tbl[23] = '{1'b1, 3'b000, 1'b0, 1'b0, 9'b000_000_0_0_0};

      arb.i_Req = '0;
      for (int i = 0; i < NV; i++) begin
         i_Reset    = tbl[i].rst;
         arb.i_Req  = tbl[i].req;
         tbl_rstok  = tbl[i].rstok;
         tbl_twosec = tbl[i].twosec;
         tick();
         check($sformatf("vec%0d", i), cur(), tbl[i].exp);
         $display("vec %0d: rst=%b req=%b rstok=%b twosec=%b -> grant=%b done=%b busy=%b",
                  i, tbl[i].rst, tbl[i].req, tbl[i].rstok, tbl[i].twosec,
                  arb.o_Grant, arb.o_Done, arb.o_Busy);
      end
      tbl_rstok  = 1'b0;
      tbl_twosec = 1'b0;
      use_model  = 1'b1;

      // Single request with full 2-second timing, then sticky release.
      do_reset();
      arb.i_Req = 3'b001;
      for (int c = 1; c <= 4100; c++) begin
         tick();
         want = {3'b001, (c == 4098) ? 3'b001 : 3'b000, 1'b1, (c == 1), (c >= 2 && c <= 4097)};
         check($sformatf("single_c%0d", c), cur(), want);
      end
      $display("single: request 001 served, Done expected in cycle 4098");
      arb.i_Req = 3'b000;
      tick();
      check("sticky_release", cur(), 9'b000_000_0_0_0);
      $display("sticky: release to idle after request drop");

      // Round-robin with all three requesting.
      rr_order[0] = 3'b001;
      rr_order[1] = 3'b010;
      rr_order[2] = 3'b100;
      rr_order[3] = 3'b001;
      do_reset();
      arb.i_Req = 3'b111;
      for (int k = 0; k < 4; k++) begin
         e = rr_order[k];
         n = 0;
         while (arb.o_Grant == 3'b000 && n < 10) begin
            tick();
            n++;
         end
         check($sformatf("rr%0d_grant", k), cur(), {e, 3'b000, 1'b1, 1'b1, 1'b0});
         n = 0;
         while (arb.o_Done == 3'b000 && n < 5000) begin
            tick();
            n++;
         end
         check($sformatf("rr%0d_done", k), cur(), {e, e, 1'b1, 1'b0, 1'b0});
         tick();
         check($sformatf("rr%0d_release", k), cur(), {e, 3'b000, 1'b1, 1'b0, 1'b0});
         arb.i_Req = 3'b111 & ~e;
         tick();
         check($sformatf("rr%0d_idle", k), cur(), 9'b000_000_0_0_0);
         arb.i_Req = (k == 3) ? 3'b000 : 3'b111;
         $display("rr %0d: granted and completed %b", k, e);
      end

      // Abort in RUN, pending requester served next.
      do_reset();
      arb.i_Req = 3'b110;
      for (int c = 1; c <= 1001; c++) begin
         tick();
         if (c == 1)         want = 9'b010_000_1_1_0;
         else if (c <= 1000) want = 9'b010_000_1_0_1;
         else                want = 9'b000_000_0_0_0;
         check($sformatf("abort_c%0d", c), cur(), want);
         if (c == 1000) arb.i_Req = 3'b100;
      end
      tick();
      check("abort_next_grant", cur(), 9'b100_000_1_1_0);
      $display("abort: 010 aborted in cycle 1000, 100 granted next");

      // Abort coinciding with terminal count.
      n = 0;
      while (!i_TwoSec && n < 5000) begin
         tick();
         n++;
      end
      check("term_twosec_seen", {8'b0, i_TwoSec}, 9'd1);
      check("term_run", cur(), 9'b100_000_1_0_1);
      arb.i_Req = 3'b000;
      tick();
      check("term_abort_idle", cur(), 9'b000_000_0_0_0);
      tick();
      check("term_no_done", cur(), 9'b000_000_0_0_0);
      $display("abort_vs_terminal: request dropped with TwoSec, no Done");

      // Reset in the middle of RUN.
      do_reset();
      arb.i_Req = 3'b001;
      for (int c = 1; c <= 500; c++) begin
         tick();
         want = (c == 1) ? 9'b001_000_1_1_0 : 9'b001_000_1_0_1;
         check($sformatf("midrst_c%0d", c), cur(), want);
      end
      i_Reset = 1'b1;
      tick();
      check("midrst_c501", cur(), 9'b000_000_0_0_0);
      i_Reset   = 1'b0;
      arb.i_Req = 3'b011;
      tick();
      check("midrst_regrant", cur(), 9'b001_000_1_1_0);
      $display("reset_mid_run: outputs cleared, search restarts at bit 0");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
